// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CAUSE_WIDTH = 2;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [CAUSE_WIDTH-1:0] CAUSE_NONE     = 2'b00;
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10
  } fetch_state_e;

  // Byte address of the sequentially next instruction (wraps modulo 2^32).
  function automatic logic [XLEN-1:0] next_word_addr(input logic [XLEN-1:0] addr);
    return addr + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: holds the fetched word and its address for decode.
module fetch_stage_if_id_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;

  // Flush wins over load; with neither the entry holds unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= next_word_addr(pc_i);
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational imem,
// feeds decode through IF/ID and parks in TRAP on a bad fetch address.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR     = 32'h0000_0100,
  parameter int unsigned IMEM_ADDR_WIDTH = 16,
  parameter logic [31:0] NOP_INSTR       = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  input  logic        fault_clear
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [1:0]       cause_q, cause_d;
  logic [31:0]      fault_addr_q, fault_addr_d;

  logic             ifid_load;
  logic             ifid_flush;
  logic             handshake;
  logic             out_of_range;

  assign handshake    = out_valid && out_ready;
  assign out_of_range = (pc_q >> IMEM_ADDR_WIDTH) != '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Next-PC selection and FSM; redirect beats range check beats sequential fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = fault_q;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          if (redirect_target[1:0] != 2'b00) begin
            state_d      = ST_TRAP;
            fault_d      = 1'b1;
            cause_d      = CAUSE_MISALIGN;
            fault_addr_d = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end else if (out_of_range) begin
          state_d      = ST_TRAP;
          fault_d      = 1'b1;
          cause_d      = CAUSE_RANGE;
          fault_addr_d = pc_q;
          ifid_flush   = handshake;
        end else if (!out_valid || out_ready) begin
          ifid_load = 1'b1;
          pc_d      = next_word_addr(pc_q);
        end
      end
      ST_TRAP: begin
        // A word captured before the fault may still drain to decode.
        ifid_flush = handshake;
        if (fault_clear) begin
          state_d = ST_RUN;
          pc_d    = TRAP_VECTOR;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  fetch_stage_if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .valid_o    (out_valid),
    .instr_o    (out_instr),
    .pc_o       (out_pc),
    .pc_plus4_o (out_pc_plus4)
  );

  assign imem_addr   = pc_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected handshaken instructions.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        fault_clear;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .fault           (fault),
    .fault_cause     (fault_cause),
    .fault_addr      (fault_addr),
    .fault_clear     (fault_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0640_0093;
      32'h0000_0004: return 32'h0C80_0113;
      default:       return {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted IF/ID entry must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected: observed pc=%h expected=none", out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
        chk("sb_pc4", out_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    fault_clear     = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc_plus4, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    chk("rst_imem", imem_addr, 32'd0);

    // T1: boot cycle then one instruction per clock
    out_ready = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    reset = 1'b0;
    tick();
    chk("boot_valid", 32'(out_valid), 32'd0);
    chk("boot_imem", imem_addr, 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_imem", imem_addr, 32'h4);
    tick();
    chk("t1_pc4", out_pc, 32'h4);
    tick();
    chk("t1_pc8", out_pc, 32'h8);
    chk("t1_imem8", imem_addr, 32'hC);

    // T2: stall keeps PC and IF/ID frozen
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t2_imem", imem_addr, 32'hC);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_pc", out_pc, 32'h8);
      chk("t2_instr", out_instr, mem_word(32'h8));
      chk("t2_pc4", out_pc_plus4, 32'hC);
    end
    out_ready = 1'b1;
    tick();
    chk("t2_next_pc", out_pc, 32'hC);
    chk("t2_next_instr", out_instr, mem_word(32'hC));

    // T3: redirect flushes a stalled entry
    out_ready       = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    chk("t3_flush_valid", 32'(out_valid), 32'd0);
    chk("t3_flush_instr", out_instr, NOP);
    chk("t3_imem", imem_addr, 32'h40);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    push_exp(32'h40);
    tick();
    chk("t3_pc", out_pc, 32'h40);
    chk("t3_valid", 32'(out_valid), 32'd1);

    // T4: misaligned redirect traps; later redirects ignored
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    tick();
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_cause", 32'(fault_cause), 32'd1);
    chk("t4_faddr", fault_addr, 32'h42);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_imem", imem_addr, 32'h44);
    redirect_target = 32'h80;
    repeat (2) begin
      tick();
      chk("t4_park_fault", 32'(fault), 32'd1);
      chk("t4_park_imem", imem_addr, 32'h44);
      chk("t4_park_valid", 32'(out_valid), 32'd0);
    end
    redirect_valid = 1'b0;
    fault_clear    = 1'b1;
    tick();
    chk("t4_clr_fault", 32'(fault), 32'd0);
    chk("t4_clr_cause", 32'(fault_cause), 32'd0);
    chk("t4_clr_faddr", fault_addr, 32'h42);
    chk("t4_clr_imem", imem_addr, 32'h100);
    fault_clear = 1'b0;
    push_exp(32'h100);
    tick();
    chk("t4_resume_pc", out_pc, 32'h100);

    // T5: last in-range word issues, then range fault
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFC;
    tick();
    chk("t5_flush", 32'(out_valid), 32'd0);
    chk("t5_imem", imem_addr, 32'hFFFC);
    redirect_valid = 1'b0;
    push_exp(32'hFFFC);
    tick();
    chk("t5_pc", out_pc, 32'hFFFC);
    chk("t5_imem_oor", imem_addr, 32'h1_0000);
    chk("t5_nofault", 32'(fault), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_cause", 32'(fault_cause), 32'd2);
    chk("t5_faddr", fault_addr, 32'h1_0000);
    chk("t5_hold_valid", 32'(out_valid), 32'd1);
    chk("t5_hold_pc", out_pc, 32'hFFFC);
    out_ready = 1'b1;
    tick();
    chk("t5_drained", 32'(out_valid), 32'd0);
    chk("t5_still_fault", 32'(fault), 32'd1);
    fault_clear = 1'b1;
    tick();
    chk("t5_clr_fault", 32'(fault), 32'd0);
    chk("t5_clr_imem", imem_addr, 32'h100);
    chk("t5_clr_faddr", fault_addr, 32'h1_0000);
    fault_clear = 1'b0;

    // T6: async reset during a stall
    push_exp(32'h100);
    push_exp(32'h104);
    push_exp(32'h108);
    tick();
    tick();
    tick();
    chk("t6_pc", out_pc, 32'h108);
    out_ready = 1'b0;
    tick();
    tick();
    chk("t6_stall_pc", out_pc, 32'h108);
    chk("t6_stall_imem", imem_addr, 32'h10C);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_imem", imem_addr, 32'd0);
    chk("t6_rst_pc", out_pc, 32'd0);
    chk("t6_rst_instr", out_instr, NOP);
    chk("t6_sb_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    push_exp(32'h0);
    tick();
    chk("t6_boot_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t6_restart_pc", out_pc, 32'h0);
    chk("t6_restart_valid", 32'(out_valid), 32'd1);
    #5;
    out_ready = 1'b0;
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
